rs_bank_arbiter: RTL and testbench



---
 rtl/rs_bank_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rs_bank_arbiter.sv | 131 +++++++++++++
 tb/tb_rs_bank_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_bank_pkg.sv
// Shared types and constants for the RS flip-flop bank arbiter.
// Holds the controller state encoding, the operation codes and the mask bus sizing helper.
package rs_bank_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_SETTLE,
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_CLEAR = 1'b0;

    function automatic int mask_bus_w(input int nreq, input int width);
        return nreq * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
// Purely combinational; no state and no backpressure of its own.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    int            cand;
    logic [PW-1:0] cand_idx;
    logic          found;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = PW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rs_bank_arbiter.sv
// Arbitrates set/clear requests onto a shared RS flip-flop bank and confirms each write by readback.
// A grant sampled in IDLE drives the bank next cycle and acks three cycles after the sample.
module rs_bank_arbiter
    import rs_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [NREQ-1:0]                     REQ,
    input  logic [NREQ-1:0]                     OP,
    input  logic [mask_bus_w(NREQ, WIDTH)-1:0]  MASK,
    input  logic [WIDTH-1:0]                    Q_IN,
    output logic [WIDTH-1:0]                    S_BUS,
    output logic [WIDTH-1:0]                    R_BUS,
    output logic [NREQ-1:0]                     ACK,
    output logic                                ERR,
    output logic                                BUSY
);

    localparam int PW = $clog2(NREQ);

    state_t            state, state_nxt;
    logic              init_drv;
    logic [PW-1:0]     ptr, win_idx, win_l;
    logic [NREQ-1:0]   grant;
    logic              op_l;
    logic [WIDTH-1:0]  mask_l, win_mask, exp_q;
    logic              mismatch;
    logic [WIDTH-1:0]  s_nxt, r_nxt;
    logic [NREQ-1:0]   ack_nxt;
    logic              err_nxt, busy_nxt;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (REQ),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign win_mask = MASK[win_idx*WIDTH +: WIDTH];
    assign exp_q    = (op_l == OP_SET) ? mask_l : '0;
    assign mismatch = (Q_IN & mask_l) != exp_q;

    always_ff @(posedge CLK) begin
        state <= state_nxt;
    end

    // Outputs are decoded from the next state so each registered value lines up with its state.
    always_comb begin
        state_nxt = state;
        s_nxt     = '0;
        r_nxt     = '0;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        busy_nxt  = 1'b1;
        case (state)
            ST_INIT: begin
                if (init_drv) begin
                    state_nxt = ST_INIT_SETTLE;
                end else begin
                    r_nxt = '1;
                end
            end
            ST_INIT_SETTLE: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
            ST_IDLE: begin
                if (|grant) begin
                    state_nxt = ST_DRIVE;
                    if (OP[win_idx] == OP_SET) begin
                        s_nxt = win_mask;
                    end else begin
                        r_nxt = win_mask;
                    end
                end else begin
                    busy_nxt = 1'b0;
                end
            end
            ST_DRIVE: begin
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt        = ST_DONE;
                ack_nxt[win_l]   = 1'b1;
                err_nxt          = mismatch;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        if (RST) begin
            state_nxt = ST_INIT;
            s_nxt     = '0;
            r_nxt     = '0;
            ack_nxt   = '0;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        S_BUS <= s_nxt;
        R_BUS <= r_nxt;
        ACK   <= ack_nxt;
        ERR   <= err_nxt;
        BUSY  <= busy_nxt;
        if (RST) begin
            init_drv <= 1'b0;
            ptr      <= '0;
        end else begin
            // First INIT cycle after reset drives the clear; the second one moves on.
            init_drv <= (state == ST_INIT);
            if (state == ST_IDLE && |grant) begin
                win_l  <= win_idx;
                op_l   <= OP[win_idx];
                mask_l <= win_mask;
            end
            if (state == ST_DONE) begin
                ptr <= (win_l == PW'(NREQ - 1)) ? '0 : win_l + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rs_bank_arbiter.sv
// Directed bench for rs_bank_arbiter with a behavioural RS bank model on the buses.
module tb_rs_bank_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ;
    logic [3:0]  OP;
    logic [31:0] MASK;
    logic [7:0]  Q_IN;
    logic [7:0]  S_BUS;
    logic [7:0]  R_BUS;
    logic [3:0]  ACK;
    logic        ERR;
    logic        BUSY;

    logic [7:0]  bank_q = 8'h3C;
    logic [7:0]  stuck0 = 8'h00;
    logic        inv_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    rs_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .OP    (OP),
        .MASK  (MASK),
        .Q_IN  (Q_IN),
        .S_BUS (S_BUS),
        .R_BUS (R_BUS),
        .ACK   (ACK),
        .ERR   (ERR),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        bank_q <= (bank_q | S_BUS) & ~R_BUS;
    end
    assign Q_IN = bank_q & ~stuck0;

    always @(negedge CLK) begin
        if (inv_en) begin
            checks++;
            assert ((S_BUS & R_BUS) === 8'h00) else begin
                errors++;
                $error("FAIL s_and_r: observed %h expected 00", S_BUS & R_BUS);
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [7:0] s, input logic [7:0] r,
                        input logic [3:0] a, input logic e, input logic b);
        chk({tag, ".s_bus"}, 32'(S_BUS), 32'(s));
        chk({tag, ".r_bus"}, 32'(R_BUS), 32'(r));
        chk({tag, ".ack"},   32'(ACK),   32'(a));
        chk({tag, ".err"},   32'(ERR),   32'(e));
        chk({tag, ".busy"},  32'(BUSY),  32'(b));
    endtask

    logic [3:0] rr_ack [4];
    logic [7:0] rr_msk [4];

    initial begin
        RST  = 1'b1;
        REQ  = 4'b0000;
        OP   = 4'b0000;
        MASK = 32'h0;

        // Reset release and bank clear
        tick;
        inv_en = 1'b1;
        outs("rst", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        tick;
        RST = 1'b0;
        tick;
        outs("init_clr", 8'h00, 8'hFF, 4'b0000, 1'b0, 1'b1);
        tick;
        outs("init_quiet", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        chk("init_bank", 32'(Q_IN), 32'h00);
        tick;
        outs("idle0", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Single set by requester 0; mask changed after DRIVE must be ignored
        REQ = 4'b0001;
        OP  = 4'b0001;
        MASK[7:0] = 8'hA5;
        tick;
        outs("set_drive", 8'hA5, 8'h00, 4'b0000, 1'b0, 1'b1);
        MASK[7:0] = 8'hFF;
        tick;
        outs("set_settle", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        tick;
        outs("set_done", 8'h00, 8'h00, 4'b0001, 1'b0, 1'b1);
        chk("set_bank", 32'(Q_IN), 32'hA5);
        REQ = 4'b0000;
        tick;
        outs("set_idle", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Requester 2 sets all bits (pointer is 1, so 2 wins)
        REQ = 4'b0100;
        OP  = 4'b0100;
        MASK[23:16] = 8'hFF;
        tick;
        outs("fill_drive", 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b1);
        tick;
        tick;
        outs("fill_done", 8'h00, 8'h00, 4'b0100, 1'b0, 1'b1);
        chk("fill_bank", 32'(Q_IN), 32'hFF);
        tick;

        // Clear after set: requester 2 clears low nibble
        OP  = 4'b0000;
        MASK[23:16] = 8'h0F;
        tick;
        outs("clr_drive", 8'h00, 8'h0F, 4'b0000, 1'b0, 1'b1);
        OP = 4'b0100;
        tick;
        outs("clr_settle", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        tick;
        outs("clr_done", 8'h00, 8'h00, 4'b0100, 1'b0, 1'b1);
        chk("clr_bank", 32'(Q_IN), 32'hF0);
        REQ = 4'b0000;
        tick;

        // Readback fault: bit 3 stuck low, requester 1 sets bit 3
        stuck0 = 8'h08;
        REQ = 4'b0010;
        OP  = 4'b0010;
        MASK[15:8] = 8'h08;
        tick;
        outs("flt_drive", 8'h08, 8'h00, 4'b0000, 1'b0, 1'b1);
        REQ = 4'b0000;
        tick;
        tick;
        outs("flt_done", 8'h00, 8'h00, 4'b0010, 1'b1, 1'b1);
        tick;
        outs("flt_idle", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        stuck0 = 8'h00;

        // Reset during DRIVE: no ack, bank cleared by INIT
        REQ = 4'b0001;
        OP  = 4'b0001;
        MASK[7:0] = 8'h3C;
        tick;
        outs("rmid_drive", 8'h3C, 8'h00, 4'b0000, 1'b0, 1'b1);
        RST = 1'b1;
        REQ = 4'b0000;
        tick;
        outs("rmid_rst", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        chk("rmid_bank_pre", 32'(Q_IN), 32'hFC);
        RST = 1'b0;
        tick;
        outs("rmid_init", 8'h00, 8'hFF, 4'b0000, 1'b0, 1'b1);
        tick;
        outs("rmid_quiet", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        chk("rmid_bank", 32'(Q_IN), 32'h00);
        tick;
        outs("rmid_idle", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Round-robin with REQ=1011 held; pointer restarts at 0 after reset
        rr_ack[0] = 4'b0001; rr_msk[0] = 8'h01;
        rr_ack[1] = 4'b0010; rr_msk[1] = 8'h02;
        rr_ack[2] = 4'b1000; rr_msk[2] = 8'h80;
        rr_ack[3] = 4'b0001; rr_msk[3] = 8'h01;
        OP   = 4'b1111;
        MASK = 32'h80_00_02_01;
        REQ  = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            tick;
            outs($sformatf("rr%0d_drive", k), rr_msk[k], 8'h00, 4'b0000, 1'b0, 1'b1);
            tick;
            tick;
            outs($sformatf("rr%0d_done", k), 8'h00, 8'h00, rr_ack[k], 1'b0, 1'b1);
            if (k == 3) REQ = 4'b0000;
            tick;
            outs($sformatf("rr%0d_idle", k), 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        end
        chk("rr_bank", 32'(Q_IN), 32'h83);

        // Zero mask: full sequence, quiet buses, ack without error (pointer is 1, so 2 wins)
        REQ = 4'b0100;
        OP  = 4'b0100;
        MASK[23:16] = 8'h00;
        tick;
        outs("zero_drive", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1);
        tick;
        tick;
        outs("zero_done", 8'h00, 8'h00, 4'b0100, 1'b0, 1'b1);
        REQ = 4'b0000;
        tick;
        outs("zero_idle", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        chk("zero_bank", 32'(Q_IN), 32'h83);

        tick;
        inv_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
